// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and default constants for the CPU clock-enable sequencer and its
// button debouncer.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STEP = 2'd1,
    ST_HALT = 2'd2
  } cpu_state_e;

  localparam int unsigned FastShiftDefault = 3;
  localparam int unsigned SlowShiftDefault = 25;
  localparam int unsigned DebCyclesDefault = 1000000;
  localparam int unsigned CntWDefault      = 32;

  // Width of a counter that must reach cycles-1.
  function automatic int unsigned deb_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted press.
module btn_debounce
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned    CntW    = deb_cnt_w(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            pulse_q, pulse_d;
  logic            target;

  // Until a stable release has been seen after reset, the counter hunts for
  // released samples only, so a button held through reset never fires.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    pulse_d = 1'b0;
    target  = armed_q ? ~level_q : 1'b0;
    if (sync2_q != target) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      if (armed_q) begin
        level_d = target;
        pulse_d = target;
      end else begin
        armed_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: fast/slow free run, single-step and halt, plus the
// free-running clkdiv bus and a retired-cycle counter.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned FAST_SHIFT = FastShiftDefault,
  parameter int unsigned SLOW_SHIFT = SlowShiftDefault,
  parameter int unsigned DEB_CYCLES = DebCyclesDefault,
  parameter int unsigned CNT_W      = CntWDefault
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             SW2,
  input  logic             step_mode,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic [CNT_W-1:0] clkdiv,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [SLOW_SHIFT-1:0] TermFast =
      SLOW_SHIFT'((64'd1 << FAST_SHIFT) - 64'd1);
  localparam logic [SLOW_SHIFT-1:0] TermSlow = '1;

  logic [CNT_W-1:0]      clkdiv_q, clkdiv_d;
  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [SLOW_SHIFT-1:0] period_q, period_d;
  logic [SLOW_SHIFT-1:0] term;
  logic                  slow_q, slow_d;
  logic                  cpu_ce_q, cpu_ce_d;
  cpu_state_e            state_q, state_d;
  logic                  ce_req;
  logic                  enter_run;
  logic                  step_pulse;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_btn (
    .clk_i  (clk100),
    .rst_i  (rst),
    .btn_i  (step_btn),
    .pulse_o(step_pulse)
  );

  assign clkdiv_d = clkdiv_q + CNT_W'(1);
  assign term     = slow_q ? TermSlow : TermFast;

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    slow_d    = slow_q;
    ce_req    = 1'b0;
    enter_run = 1'b0;
    // halt_req outranks everything, including a pending terminal count.
    if (halt_req) begin
      state_d = ST_HALT;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (step_mode) begin
            state_d = ST_STEP;
          end else if (period_q == term) begin
            ce_req   = 1'b1;
            period_d = '0;
            slow_d   = SW2;
          end else begin
            period_d = period_q + SLOW_SHIFT'(1);
          end
        end
        ST_STEP: begin
          if (step_pulse) begin
            ce_req = 1'b1;
          end else if (!step_mode) begin
            enter_run = 1'b1;
          end
        end
        ST_HALT: begin
          if (step_mode) begin
            state_d = ST_STEP;
          end else if (step_pulse) begin
            enter_run = 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    if (enter_run) begin
      state_d  = ST_RUN;
      period_d = '0;
      slow_d   = SW2;
    end
    cpu_ce_d    = ce_req & ~cpu_ce_q;
    cycle_cnt_d = cycle_cnt_q + CNT_W'(cpu_ce_d);
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      clkdiv_q    <= '0;
      cycle_cnt_q <= '0;
      period_q    <= '0;
      slow_q      <= 1'b0;
      cpu_ce_q    <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      clkdiv_q    <= clkdiv_d;
      cycle_cnt_q <= cycle_cnt_d;
      period_q    <= period_d;
      slow_q      <= slow_d;
      cpu_ce_q    <= cpu_ce_d;
      state_q     <= state_d;
    end
  end

  assign clkdiv    = clkdiv_q;
  assign cpu_ce    = cpu_ce_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: table-driven run-mode vectors, hand-written step/halt/
// reset/wrap sequences, and random stimulus against a time-based reference model.
module tb_cpu_clk_ctrl;

  localparam int unsigned FastShift = 2;
  localparam int unsigned SlowShift = 4;
  localparam int unsigned DebCycles = 4;
  localparam int unsigned CntW      = 32;

  logic            clk100 = 1'b0;
  logic            rst = 1'b1;
  logic            sw2 = 1'b0;
  logic            step_mode = 1'b0;
  logic            step_btn = 1'b0;
  logic            halt_req = 1'b0;
  logic [CntW-1:0] clkdiv;
  logic            cpu_ce;
  logic [1:0]      state;
  logic [CntW-1:0] cycle_cnt;

  always #5 clk100 = ~clk100;

  cpu_clk_ctrl #(
    .FAST_SHIFT(FastShift),
    .SLOW_SHIFT(SlowShift),
    .DEB_CYCLES(DebCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .SW2      (sw2),
    .step_mode(step_mode),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .clkdiv   (clkdiv),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ce_seen = 0;

  // Reference model: RUN pulses are scheduled as absolute fire times.
  longint      m_time = 0;
  longint      m_fire = 0;
  int          m_state = 0;
  bit          m_ce = 0;
  bit [31:0]   m_div = 0;
  bit [31:0]   m_cnt = 0;
  bit          m_s1 = 0, m_s2 = 0, m_deb = 0, m_armed = 0, m_pulse = 0;
  bit          hist[$];

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint period(input bit slow);
    return slow ? (longint'(1) << SlowShift) : (longint'(1) << FastShift);
  endfunction

  function automatic bit all_of(input bit v);
    if (hist.size() != DebCycles) return 1'b0;
    foreach (hist[i]) if (hist[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_time  = 0;
    m_fire  = period(1'b0);
    m_state = 0;
    m_ce    = 0;
    m_div   = 0;
    m_cnt   = 0;
    m_s1    = 0;
    m_s2    = 0;
    m_deb   = 0;
    m_armed = 0;
    m_pulse = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    bit ce_n;
    int st_n;
    bit sample;
    bit pulse_n;
    if (rst) begin
      model_reset();
      return;
    end
    m_time++;
    m_div++;
    ce_n = 0;
    st_n = m_state;
    if (halt_req) begin
      st_n = 2;
    end else if (m_state == 0) begin
      if (step_mode) st_n = 1;
      else if (m_time == m_fire) begin
        ce_n   = 1;
        m_fire = m_time + period(sw2);
      end
    end else if (m_state == 1) begin
      if (m_pulse) ce_n = 1;
      else if (!step_mode) begin
        st_n   = 0;
        m_fire = m_time + period(sw2);
      end
    end else begin
      if (step_mode) st_n = 1;
      else if (m_pulse) begin
        st_n   = 0;
        m_fire = m_time + period(sw2);
      end
    end
    if (m_ce) ce_n = 0;
    m_ce    = ce_n;
    m_cnt   = m_cnt + 32'(ce_n);
    m_state = st_n;
    // Button: two sync stages, then a window of the last DebCycles samples.
    sample = m_s2;
    m_s2   = m_s1;
    m_s1   = step_btn;
    hist.push_back(sample);
    if (hist.size() > DebCycles) void'(hist.pop_front());
    pulse_n = 0;
    if (!m_armed) m_armed = all_of(1'b0);
    else if (!m_deb && all_of(1'b1)) begin
      m_deb   = 1;
      pulse_n = 1;
    end else if (m_deb && all_of(1'b0)) m_deb = 0;
    m_pulse = pulse_n;
  endtask

  task automatic check_all();
    chk("cpu_ce", cpu_ce, m_ce);
    chk("state", state, m_state);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("clkdiv", clkdiv, m_div);
    if (cpu_ce) ce_seen++;
  endtask

  task automatic cycle();
    @(posedge clk100);
    model_edge();
    @(negedge clk100);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Press the button (with an optional 3-cycle bounce) and return the number
  // of edges from the start of the stable press to the cpu_ce pulse.
  task automatic press(input bit bounce, output int lat);
    if (bounce) begin
      step_btn = 1'b1;
      cycle();
      step_btn = 1'b0;
      cycle();
      cycle();
    end
    step_btn = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      cycle();
      if (cpu_ce) lat = n;
    end
  endtask

  typedef struct {
    bit rst;
    bit sw2;
    bit exp_ce;
    int exp_cyc;
    int exp_div;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit r, input bit s, input bit ce, input int cyc,
                                  input int div);
    vec_t v;
    v.rst     = r;
    v.sw2     = s;
    v.exp_ce  = ce;
    v.exp_cyc = cyc;
    v.exp_div = div;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int lat;
    int t;
    int ce_base;
    int cyc;
    bit [31:0] cnt_before;
    bit ce;

    // Fast run from reset, then SW2 raised mid-period (boundary at cycle 8).
    add_vec(1'b1, 1'b0, 1'b0, 0, 0);
    for (int k = 1; k <= 20; k++) add_vec(1'b0, 1'b0, (k % 4) == 0, k / 4, k);
    add_vec(1'b1, 1'b0, 1'b0, 0, 0);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      ce = (k == 4) || (k == 8) || (k == 24) || (k == 40);
      cyc += int'(ce);
      add_vec(1'b0, k >= 6, ce, cyc, k);
    end
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      sw2 = vecs[i].sw2;
      cycle();
      chk("vec_ce", cpu_ce, vecs[i].exp_ce);
      chk("vec_state", state, 0);
      chk("vec_cycle_cnt", cycle_cnt, vecs[i].exp_cyc);
      chk("vec_clkdiv", clkdiv, vecs[i].exp_div);
    end
    rst = 1'b0;
    sw2 = 1'b0;

    // Single-step: three clean presses and one bouncing press.
    step_mode = 1'b1;
    do_reset();
    repeat (8) cycle();
    chk("step_entry_state", state, 1);
    ce_base = ce_seen;
    for (int p = 0; p < 4; p++) begin
      press(p == 3, lat);
      chk("step_latency", lat, 7);
      step_btn = 1'b0;
      repeat (12) cycle();
    end
    chk("step_pulse_count", ce_seen - ce_base, 4);
    chk("step_final_state", state, 1);

    // Halt coincident with a terminal count, then resume by button.
    step_mode = 1'b0;
    do_reset();
    repeat (7) cycle();
    halt_req = 1'b1;
    cycle();
    chk("halt_drops_ce", cpu_ce, 0);
    chk("halt_state", state, 2);
    halt_req = 1'b0;
    repeat (10) cycle();
    chk("halt_holds", state, 2);
    step_btn = 1'b1;
    t = 0;
    for (int n = 1; n <= 20 && t == 0; n++) begin
      cycle();
      if (state == 2'd0) t = n;
    end
    chk("resume_latency", t, 7);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      cycle();
      if (cpu_ce) lat = n;
    end
    chk("resume_first_ce", lat, 4);
    step_btn = 1'b0;
    repeat (10) cycle();

    // Reset mid-step with the button held: no pulse until released and re-pressed.
    step_mode = 1'b1;
    repeat (3) cycle();
    step_btn = 1'b1;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_clkdiv", clkdiv, 0);
    chk("rst_cpu_ce", cpu_ce, 0);
    chk("rst_state", state, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    ce_base = ce_seen;
    repeat (30) cycle();
    chk("held_no_ce", ce_seen - ce_base, 0);
    step_btn = 1'b0;
    repeat (12) cycle();
    press(1'b0, lat);
    chk("repress_latency", lat, 7);
    step_btn = 1'b0;
    repeat (12) cycle();

    // clkdiv wrap from a preloaded value.
    cnt_before = m_cnt;
    force dut.clkdiv_d = 32'hFFFF_FFFE;
    @(posedge clk100);
    model_edge();
    m_div = 32'hFFFF_FFFE;
    #1 release dut.clkdiv_d;
    @(negedge clk100);
    check_all();
    chk("div_preload", clkdiv, 32'hFFFF_FFFE);
    cycle();
    cycle();
    chk("div_wrap", clkdiv, 0);
    chk("wrap_cycle_cnt", cycle_cnt, cnt_before);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 59) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 79) == 0) step_mode = ~step_mode;
      if ($urandom_range(0, 29) == 0) sw2 = ~sw2;
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
